// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg
//   Shared definitions for the 68000-bus RAM slice: the bus FSM state
//   encoding, the byte-lane count helper and the rw pin encoding.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // rw pin polarity as seen on the 68000 bus
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One strobe per byte lane.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/m68k_bus_ram_if.sv
// m68k_bus_ram_if
//   CPU-side bus bundle for a 68000-style RAM slave.
//   addr        word address
//   data_write  write data from master
//   data_read   registered read data from slave
//   ds          byte strobes, active high; MSB lane = even byte (UDS), bit0 = LDS
//   rw          1 = read, 0 = write
//   ack         one-clock transfer-complete pulse
//   berr        one-clock bus-error pulse
interface m68k_bus_ram_if
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0]               addr;
  logic [DATA_W-1:0]               data_write;
  logic [DATA_W-1:0]               data_read;
  logic [lane_count(DATA_W)-1:0]   ds;
  logic                            rw;
  logic                            ack;
  logic                            berr;

  modport master (
    output addr, data_write, ds, rw,
    input  data_read, ack, berr
  );

  modport slave (
    input  addr, data_write, ds, rw,
    output data_read, ack, berr
  );

endinterface

// File: rtl/m68k_ram_core.sv
// m68k_ram_core
//   Byte-lane RAM array with synchronous (registered) read and per-lane
//   write enables. Contains no bus logic; the caller gates enables.
//   clk      system clock
//   reset_n  async active-low reset (clears the read register only)
//   idx      word index
//   wdata    write data
//   we       per-lane write enable
//   re       per-lane read enable; lanes not enabled keep their old value
//   rdata    registered read data
module m68k_ram_core
  import m68k_bus_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 131072,
  parameter int IDX_W  = 17
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IDX_W-1:0]                idx,
  input  logic [DATA_W-1:0]               wdata,
  input  logic [lane_count(DATA_W)-1:0]   we,
  input  logic [lane_count(DATA_W)-1:0]   re,
  output logic [DATA_W-1:0]               rdata
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (re[i]) rdata[i*8 +: 8] <= mem[idx][i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/m68k_bus_ram.sv
// m68k_bus_ram
//   Parametrised 68000-bus RAM slave. Samples a bus cycle when any strobe
//   goes high, waits WAIT_STATES clocks, then performs the access and
//   returns a single ack (or berr for out-of-range / protected accesses).
//   clk       system clock, rising edge
//   reset_n   async active-low reset
//   bus       m68k_bus_ram_if.slave (addr, data_write, data_read, ds, rw, ack, berr)
// Build option:
//   M68K_RAM_WPROT_EN  when defined, writes to WP_BASE..WP_LIMIT return berr
//                      and leave memory unchanged. Requires WP_BASE <= WP_LIMIT.
module m68k_bus_ram
  import m68k_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int DEPTH       = 131072,
  parameter int WAIT_STATES = 0,
  parameter int WP_BASE     = 0,
  parameter int WP_LIMIT    = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  m68k_bus_ram_if.slave      bus
);

  localparam int LANES = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WP_LO     = ADDR_W'(WP_BASE);
  localparam logic [ADDR_W-1:0] WP_HI     = ADDR_W'(WP_LIMIT);
  localparam logic [ADDR_W-1:0] WP_SPAN   = WP_HI - WP_LO;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_rw;
  logic [LANES-1:0]    lat_ds;
  logic [DATA_W-1:0]   lat_wdata;
  logic                ack_q, berr_q;

  logic                any_ds;
  logic                capture, fire, cnt_dec;
  logic                out_of_range, wp_range, wp_hit, fault;
  logic [ADDR_W-1:0]   wp_off;
  logic [LANES-1:0]    we, re;
  logic [DATA_W-1:0]   rdata;

  assign any_ds = |bus.ds;

  assign out_of_range = ({1'b0, lat_addr} >= DEPTH_LIM);

  // Offset compare avoids a constant ">= 0" when WP_BASE is zero.
  assign wp_off   = lat_addr - WP_LO;
  assign wp_range = !(wp_off > WP_SPAN);

`ifdef M68K_RAM_WPROT_EN
  assign wp_hit = (lat_rw == RW_WRITE) && wp_range;
`else
  // Window compare kept elaborated but never allowed to fault.
  assign wp_hit = 1'b0 & wp_range;
`endif

  assign fault = out_of_range | wp_hit;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cnt_dec   = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_ds) begin
          capture   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Strobes released before completion: abandon the cycle silently.
        if (!any_ds) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_dec = 1'b1;
        end else begin
          fire      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!any_ds) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we = '0;
    re = '0;
    if (fire && !fault && (lat_rw == RW_WRITE)) we = lat_ds;
    if (fire && !out_of_range && (lat_rw == RW_READ)) re = lat_ds;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_rw    <= RW_READ;
      lat_ds    <= '0;
      lat_wdata <= '0;
      ack_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack_q  <= fire && !fault;
      berr_q <= fire && fault;
      if (capture) begin
        cnt       <= 4'(WAIT_STATES);
        lat_addr  <= bus.addr;
        lat_rw    <= bus.rw;
        lat_ds    <= bus.ds;
        lat_wdata <= bus.data_write;
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  m68k_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .idx     (lat_addr[IDX_W-1:0]),
    .wdata   (lat_wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata)
  );

  assign bus.data_read = rdata;
  assign bus.ack       = ack_q;
  assign bus.berr      = berr_q;

endmodule

// File: tb/tb_m68k_bus_ram.sv
// tb_m68k_bus_ram
//   Two RAM instances share clock and reset: u_ws0 (no wait states,
//   write-protect window 0x100..0x1FF) and u_ws3 (three wait states).
//   Each bus cycle pushes its expectation from a shadow model onto a
//   scoreboard queue; the observed ack/berr/latency/data are popped and
//   compared once the cycle completes.
module tb_m68k_bus_ram;
  import m68k_bus_pkg::*;

  localparam int DEPTH = 131072;

  typedef struct {
    string       tag;
    int          lat;
    logic        ack;
    logic        berr;
    logic [15:0] rd;
  } exp_t;

  logic clk;
  logic reset_n;

  m68k_bus_ram_if #(.ADDR_W(18), .DATA_W(16)) b0 ();
  m68k_bus_ram_if #(.ADDR_W(18), .DATA_W(16)) b3 ();

  m68k_bus_ram #(
    .DATA_W(16), .ADDR_W(18), .DEPTH(DEPTH), .WAIT_STATES(0),
    .WP_BASE(32'h100), .WP_LIMIT(32'h1FF)
  ) u_ws0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );

  m68k_bus_ram #(
    .DATA_W(16), .ADDR_W(18), .DEPTH(DEPTH), .WAIT_STATES(3),
    .WP_BASE(0), .WP_LIMIT(0)
  ) u_ws3 (
    .clk(clk), .reset_n(reset_n), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb [$];
  logic [15:0] mdl0 [int];
  logic [15:0] mdl3 [int];
  logic [15:0] rd0 = 16'h0;
  logic [15:0] rd3 = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [17:0] a, input logic rw,
                       input logic [1:0] ds, input logic [15:0] wd);
    if (sel == 0) begin
      b0.addr = a; b0.rw = rw; b0.ds = ds; b0.data_write = wd;
    end else begin
      b3.addr = a; b3.rw = rw; b3.ds = ds; b3.data_write = wd;
    end
  endtask

  task automatic set_ds(input int sel, input logic [1:0] ds);
    if (sel == 0) b0.ds = ds;
    else          b3.ds = ds;
  endtask

  // Shadow model: derives expected response and updates model state.
  task automatic push_exp(input string tag, input int sel, input logic [17:0] a,
                          input logic rw, input logic [1:0] ds, input logic [15:0] wd,
                          input logic aborted);
    exp_t        e;
    logic [15:0] prev, cur;
    logic        prot;
    int          ws;
    ws   = (sel == 0) ? 0 : 3;
    prot = 1'b0;
`ifdef M68K_RAM_WPROT_EN
    prot = (sel == 0) && !rw && (a >= 18'h100) && (a <= 18'h1FF);
`endif
    prev  = (sel == 0) ? rd0 : rd3;
    e.tag = tag;
    e.rd  = prev;
    if (aborted) begin
      e.lat = -1; e.ack = 1'b0; e.berr = 1'b0;
    end else if (int'(a) >= DEPTH || prot) begin
      e.lat = ws + 1; e.ack = 1'b0; e.berr = 1'b1;
    end else begin
      e.lat = ws + 1; e.ack = 1'b1; e.berr = 1'b0;
      if (sel == 0) cur = mdl0.exists(int'(a)) ? mdl0[int'(a)] : 16'h0;
      else          cur = mdl3.exists(int'(a)) ? mdl3[int'(a)] : 16'h0;
      if (rw) begin
        if (ds[1]) e.rd[15:8] = cur[15:8];
        if (ds[0]) e.rd[7:0]  = cur[7:0];
        if (sel == 0) rd0 = e.rd;
        else          rd3 = e.rd;
      end else begin
        if (ds[1]) cur[15:8] = wd[15:8];
        if (ds[0]) cur[7:0]  = wd[7:0];
        if (sel == 0) mdl0[int'(a)] = cur;
        else          mdl3[int'(a)] = cur;
      end
    end
    sb.push_back(e);
  endtask

  // One bus cycle. Strobes stay high for 16 clocks after the sampling edge
  // (or are dropped after abort_after clocks) so a second pulse would show.
  task automatic run_cycle(input string tag, input int sel, input logic [17:0] a,
                           input logic rw, input logic [1:0] ds, input logic [15:0] wd,
                           input int abort_after);
    exp_t        e;
    int          lat, pulses;
    logic        got_ack, got_berr, av, bv;
    logic [15:0] rd, dv;
    push_exp(tag, sel, a, rw, ds, wd, abort_after >= 0);
    @(negedge clk);
    drive(sel, a, rw, ds, wd);
    @(posedge clk);
    lat = -1; pulses = 0; got_ack = 1'b0; got_berr = 1'b0; rd = 16'h0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      av = (sel == 0) ? b0.ack : b3.ack;
      bv = (sel == 0) ? b0.berr : b3.berr;
      dv = (sel == 0) ? b0.data_read : b3.data_read;
      if (av || bv) begin
        pulses++;
        if (lat < 0) begin
          lat = c; got_ack = av; got_berr = bv; rd = dv;
        end
      end
      if (c == abort_after) set_ds(sel, 2'b00);
    end
    if (lat < 0) rd = (sel == 0) ? b0.data_read : b3.data_read;
    set_ds(sel, 2'b00);
    @(posedge clk);
    @(posedge clk);
    e = sb.pop_front();
    check({e.tag, ".lat"},    lat,      e.lat);
    check({e.tag, ".ack"},    got_ack,  e.ack);
    check({e.tag, ".berr"},   got_berr, e.berr);
    check({e.tag, ".pulses"}, pulses,   (e.ack || e.berr) ? 1 : 0);
    check({e.tag, ".data"},   rd,       e.rd);
  endtask

  logic seen;

  initial begin
    reset_n = 1'b0;
    drive(0, 18'h0, 1'b1, 2'b00, 16'h0);
    drive(3, 18'h0, 1'b1, 2'b00, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.ack0",  b0.ack,       1'b0);
    check("rst.berr0", b0.berr,      1'b0);
    check("rst.data0", b0.data_read, 16'h0);
    check("rst.ack3",  b3.ack,       1'b0);
    check("rst.berr3", b3.berr,      1'b0);
    check("rst.data3", b3.data_read, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);

    // Full-word write/read, no wait states
    run_cycle("t1.wr",   0, 18'h00010, 1'b0, 2'b11, 16'hBEEF, -1);
    run_cycle("t1.rd",   0, 18'h00010, 1'b1, 2'b11, 16'h0000, -1);

    // Lane writes
    run_cycle("t2.wr_u", 0, 18'h00010, 1'b0, 2'b10, 16'h12AA, -1);
    run_cycle("t2.rd_u", 0, 18'h00010, 1'b1, 2'b11, 16'h0000, -1);
    run_cycle("t2.wr_l", 0, 18'h00010, 1'b0, 2'b01, 16'hCD34, -1);
    run_cycle("t2.rd_l", 0, 18'h00010, 1'b1, 2'b11, 16'h0000, -1);
    run_cycle("t2.wr_b", 0, 18'h00020, 1'b0, 2'b11, 16'hA5A5, -1);
    run_cycle("t2.rd_lo",0, 18'h00020, 1'b1, 2'b01, 16'h0000, -1);

    // Range boundary
    run_cycle("t4.wr0",  0, 18'h00000, 1'b0, 2'b11, 16'h7777, -1);
    run_cycle("t4.rd_oor",0,18'h20000, 1'b1, 2'b11, 16'h0000, -1);
    run_cycle("t4.wr_oor",0,18'h20000, 1'b0, 2'b11, 16'h1111, -1);
    run_cycle("t4.rd0",  0, 18'h00000, 1'b1, 2'b11, 16'h0000, -1);
    run_cycle("t4.wr_last",0,18'h1FFFF,1'b0, 2'b11, 16'h3C3C, -1);
    run_cycle("t4.rd_last",0,18'h1FFFF,1'b1, 2'b11, 16'h0000, -1);

    // Wait states, long strobe hold
    run_cycle("t3.wr",   3, 18'h00030, 1'b0, 2'b11, 16'h0F0F, -1);
    run_cycle("t3.rd",   3, 18'h00030, 1'b1, 2'b11, 16'h0000, -1);

    // Abort in ACCESS
    run_cycle("t5.wr",   3, 18'h00040, 1'b0, 2'b11, 16'hAAAA, -1);
    run_cycle("t5.abort",3, 18'h00040, 1'b0, 2'b11, 16'h5555, 2);
    run_cycle("t5.rd",   3, 18'h00040, 1'b1, 2'b11, 16'h0000, -1);

    // Reset asserted mid-ACCESS
    @(negedge clk);
    drive(3, 18'h00030, 1'b1, 2'b11, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    rd0 = 16'h0;
    rd3 = 16'h0;
    #1;
    check("t5.rst.ack",  b3.ack,       1'b0);
    check("t5.rst.berr", b3.berr,      1'b0);
    check("t5.rst.data", b3.data_read, 16'h0);
    set_ds(3, 2'b00);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      seen = seen | b3.ack | b3.berr;
    end
    check("t5.rst.quiet", seen, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_cycle("t5.rd_after_rst", 3, 18'h00040, 1'b1, 2'b11, 16'h0000, -1);
    run_cycle("t5.rd_ws0_after", 0, 18'h00020, 1'b1, 2'b10, 16'h0000, -1);

    // Write-protect window (berr only when the option is built in)
    run_cycle("t6.wr_wp", 0, 18'h00180, 1'b0, 2'b11, 16'h5555, -1);
`ifndef M68K_RAM_WPROT_EN
    run_cycle("t6.rd_wp", 0, 18'h00180, 1'b1, 2'b11, 16'h0000, -1);
`endif
    run_cycle("t6.wr_ok", 0, 18'h00200, 1'b0, 2'b11, 16'h6666, -1);
    run_cycle("t6.rd_ok", 0, 18'h00200, 1'b1, 2'b11, 16'h0000, -1);

    check("sb.empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
